// File: rtl/wash_pkg.sv
// -----------------------------------------------------------------------------
// wash_pkg
// Shared definitions for the washing-machine program sequencer:
//   - phase_t      : 3-bit phase encoding as seen on the phase output
//   - LIGHT_*      : status LED patterns per phase
//   - bcd_load     : binary 0..99 -> two packed BCD digits {tens, units}
//   - bcd_dec      : two-digit BCD decrement (caller guarantees value > 00)
//   - light_for    : LED pattern for a non-PAUSE phase
// -----------------------------------------------------------------------------
package wash_pkg;

   typedef enum logic [2:0] {
      PH_IDLE  = 3'd0,
      PH_FILL  = 3'd1,
      PH_WASH  = 3'd2,
      PH_DRAIN = 3'd3,
      PH_SPIN  = 3'd4,
      PH_DONE  = 3'd5,
      PH_PAUSE = 3'd6
   } phase_t;

   localparam logic [7:0] LIGHT_IDLE       = 8'h00;
   localparam logic [7:0] LIGHT_FILL       = 8'h01;
   localparam logic [7:0] LIGHT_WASH       = 8'h03;
   localparam logic [7:0] LIGHT_DRAIN      = 8'h07;
   localparam logic [7:0] LIGHT_SPIN       = 8'h0F;
   localparam logic [7:0] LIGHT_DONE       = 8'hFF;
   localparam logic [7:0] LIGHT_PAUSE_FLAG = 8'h80;

   function automatic logic [7:0] bcd_load(input int unsigned value);
      int unsigned tens;
      int unsigned units;
      tens  = value / 10;
      units = value % 10;
      return {tens[3:0], units[3:0]};
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] bcd);
      logic [7:0] result;
      if (bcd[3:0] == 4'd0) result = {bcd[7:4] - 4'd1, 4'd9};
      else                  result = {bcd[7:4], bcd[3:0] - 4'd1};
      return result;
   endfunction

   function automatic logic [7:0] light_for(input phase_t ph);
      logic [7:0] result;
      case (ph)
         PH_FILL:  result = LIGHT_FILL;
         PH_WASH:  result = LIGHT_WASH;
         PH_DRAIN: result = LIGHT_DRAIN;
         PH_SPIN:  result = LIGHT_SPIN;
         PH_DONE:  result = LIGHT_DONE;
         default:  result = LIGHT_IDLE;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/wash_bcd_timer.sv
// -----------------------------------------------------------------------------
// wash_bcd_timer
// Seconds prescaler plus two-digit BCD down-counter for one wash phase.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   load          restart: digits <= load_val, prescaler cleared (wins over run)
//   load_val[7:0] BCD value to load
//   run           prescaler advances only while high; held otherwise
//   tick          one-cycle strobe when the prescaler is at CLK_HZ-1 and running
//   last          tick while the count reads 01 (phase ends this cycle)
//   digits[7:0]   {tens, units} BCD remaining seconds
// The counter never decrements below 01; the owner reloads it on last.
// -----------------------------------------------------------------------------
module wash_bcd_timer
   import wash_pkg::*;
#(
   parameter int unsigned CLK_HZ = 100000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       run,
   output logic       tick,
   output logic       last,
   output logic [7:0] digits
);

   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

   logic [PW-1:0] presc;

   assign tick = run && (presc == PRESC_MAX);
   assign last = tick && (digits == 8'h01);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc  <= '0;
         digits <= 8'h00;
      end else if (load) begin
         presc  <= '0;
         digits <= load_val;
      end else if (run) begin
         if (tick) begin
            presc <= '0;
            if (digits > 8'h01) digits <= bcd_dec(digits);
         end else begin
            presc <= presc + 1'b1;
         end
      end
   end

endmodule

// File: rtl/wash_sequencer.sv
// -----------------------------------------------------------------------------
// wash_sequencer
// Washing-machine program sequencer: FILL -> WASH -> DRAIN (-> FILL per rinse)
// -> SPIN -> DONE, with pause/resume and a per-phase BCD seconds countdown.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   start, pause      one-cycle front-panel pulses
//   rinses[1:0]       extra fill/wash/drain passes, sampled at start from IDLE
//   door_closed       door switch, 1 = closed
//   phase[2:0]        current phase (wash_pkg::phase_t encoding)
//   sec_hi, sec_lo    BCD remaining seconds of the current phase
//   valve_on, motor_on, pump_on   actuator enables
//   busy, done        program running / program finished
//   door_lock         (DOOR_INTERLOCK_EN only) door held locked while running
//   st_light[7:0]     status LEDs
// Build option: define DOOR_INTERLOCK_EN to make an open door in any active
// phase behave as a pause pulse and to add the door_lock output.
// All outputs are registered from the next-state decode.
// -----------------------------------------------------------------------------
module wash_sequencer
   import wash_pkg::*;
#(
   parameter int unsigned CLK_HZ  = 100000000,
   parameter int unsigned FILL_S  = 10,
   parameter int unsigned WASH_S  = 40,
   parameter int unsigned DRAIN_S = 10,
   parameter int unsigned SPIN_S  = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       pause,
   input  logic [1:0] rinses,
   input  logic       door_closed,
   output logic [2:0] phase,
   output logic [3:0] sec_hi,
   output logic [3:0] sec_lo,
   output logic       valve_on,
   output logic       motor_on,
   output logic       pump_on,
   output logic       busy,
   output logic       done,
`ifdef DOOR_INTERLOCK_EN
   output logic       door_lock,
`endif
   output logic [7:0] st_light
);

   localparam logic [7:0] FILL_BCD  = bcd_load(FILL_S);
   localparam logic [7:0] WASH_BCD  = bcd_load(WASH_S);
   localparam logic [7:0] DRAIN_BCD = bcd_load(DRAIN_S);
   localparam logic [7:0] SPIN_BCD  = bcd_load(SPIN_S);

   phase_t     state, state_next;
   phase_t     saved, saved_next;
   phase_t     follow;
   logic [1:0] rinse, rinse_next;
   logic       tmr_load;
   logic [7:0] tmr_val;
   logic       tick, last, active, pause_req, phase_end;
   logic [7:0] digits;
   logic       valve_next, motor_next, pump_next, busy_next, done_next;
   logic [7:0] light_next;

   assign active = state inside {PH_FILL, PH_WASH, PH_DRAIN, PH_SPIN};
   // last already implies tick; both named so the phase-end condition reads plainly.
   assign phase_end = tick & last;

`ifdef DOOR_INTERLOCK_EN
   assign pause_req = pause | ~door_closed;
`else
   assign pause_req = pause;
`endif

   // The timer runs for every cycle spent in an active phase, including the
   // cycle in which a pause is sampled, so the fraction of a second already
   // elapsed is exactly what resumes after PAUSE.
   wash_bcd_timer #(.CLK_HZ(CLK_HZ)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .run      (active),
      .tick     (tick),
      .last     (last),
      .digits   (digits)
   );

   assign {sec_hi, sec_lo} = digits;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= PH_IDLE;
         saved <= PH_IDLE;
         rinse <= 2'd0;
      end else begin
         state <= state_next;
         saved <= saved_next;
         rinse <= rinse_next;
      end
   end

   always_comb begin
      state_next = state;
      saved_next = saved;
      rinse_next = rinse;
      follow     = state;
      tmr_load   = 1'b0;
      tmr_val    = 8'h00;
      case (state)
         PH_IDLE: begin
            if (start && door_closed) begin
               state_next = PH_FILL;
               rinse_next = rinses;
               tmr_load   = 1'b1;
               tmr_val    = FILL_BCD;
            end
         end
         PH_FILL, PH_WASH, PH_DRAIN, PH_SPIN: begin
            if (phase_end) begin
               case (state)
                  PH_FILL: follow = PH_WASH;
                  PH_WASH: follow = PH_DRAIN;
                  PH_DRAIN: begin
                     if (rinse != 2'd0) begin
                        follow     = PH_FILL;
                        rinse_next = rinse - 2'd1;
                     end else begin
                        follow = PH_SPIN;
                     end
                  end
                  default: follow = PH_DONE;
               endcase
               tmr_load = 1'b1;
               case (follow)
                  PH_FILL:  tmr_val = FILL_BCD;
                  PH_WASH:  tmr_val = WASH_BCD;
                  PH_DRAIN: tmr_val = DRAIN_BCD;
                  PH_SPIN:  tmr_val = SPIN_BCD;
                  default:  tmr_val = 8'h00;
               endcase
            end
            // A pause landing on a phase boundary parks the machine at the start
            // of the following phase; finishing the program cannot be paused.
            if (pause_req && follow != PH_DONE) begin
               state_next = PH_PAUSE;
               saved_next = follow;
            end else begin
               state_next = follow;
            end
         end
         PH_DONE: begin
            if (start) state_next = PH_IDLE;
         end
         PH_PAUSE: begin
            if (start && door_closed) state_next = saved;
         end
         default: state_next = PH_IDLE;
      endcase
   end

   always_comb begin
      valve_next = (state_next == PH_FILL);
      motor_next = (state_next == PH_WASH) || (state_next == PH_SPIN);
      pump_next  = (state_next == PH_DRAIN) || (state_next == PH_SPIN);
      busy_next  = (state_next != PH_IDLE) && (state_next != PH_DONE);
      done_next  = (state_next == PH_DONE);
      if (state_next == PH_PAUSE) light_next = light_for(saved_next) | LIGHT_PAUSE_FLAG;
      else                        light_next = light_for(state_next);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase    <= PH_IDLE;
         valve_on <= 1'b0;
         motor_on <= 1'b0;
         pump_on  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         st_light <= LIGHT_IDLE;
`ifdef DOOR_INTERLOCK_EN
         door_lock <= 1'b0;
`endif
      end else begin
         phase    <= state_next;
         valve_on <= valve_next;
         motor_on <= motor_next;
         pump_on  <= pump_next;
         busy     <= busy_next;
         done     <= done_next;
         st_light <= light_next;
`ifdef DOOR_INTERLOCK_EN
         door_lock <= busy_next && (state_next != PH_PAUSE);
`endif
      end
   end

endmodule
